fetch_unit: RTL and testbench

Parametrised instruction fetch stage for the RV32I microcontroller. It sits between the core's decode/execute stages and the instruction memory. It issues sequential fetch requests over a valid/ready interface with a bounded number in flight, and buffers returned instructions in a small FIFO tagged with their PC. On a branch or jump redirect it flushes the FIFO and discards stale in-flight responses. A misaligned redirect target halts the unit with a fault flag.

---
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with credit-limited requests,
// a PC-tagged instruction FIFO, redirect flush and misaligned-target halt.
module fetch_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_pc
);
    localparam int unsigned       PW   = $clog2(DEPTH);
    localparam int unsigned       CW   = $clog2(DEPTH + 1);
    localparam int unsigned       SW   = CW + 2;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    typedef enum logic {RUN, HALT} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     live_q, live_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;

    logic [DEPTH-1:0][31:0]     data_q;
    logic [DEPTH-1:0][ADDR_W-1:0] pc_q;

    logic          run, redir, misalign, credit;
    logic          req_fire, pop, rsp_drop, rsp_live, push;
    logic [SW-1:0] inflight;

    assign run      = (state_q == RUN);
    assign redir    = run && redirect_valid;
    assign misalign = (redirect_pc[1:0] != 2'b00);

    // Every FIFO slot, outstanding request and to-be-dropped response holds a credit,
    // so the FIFO can never overflow no matter how late decode pops.
    assign inflight = SW'(count_q) + SW'(live_q) + SW'(drop_q);
    assign credit   = (inflight < SW'(DEPTH));

    assign imem_req_valid = !reset && run && !redirect_valid && credit;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Head is read straight from registered storage, so a push is only visible next cycle.
    assign instr_valid = run && (count_q != '0);
    assign instr       = data_q[rd_ptr_q];
    assign instr_pc    = pc_q[rd_ptr_q];
    assign pop         = instr_valid && instr_ready;

    // Responses are in order: stale ones (counted in drop) always arrive before live ones.
    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_live = imem_rsp_valid && (drop_q == '0) && (live_q != '0);
    assign push     = rsp_live && run && !redirect_valid;

    assign fault    = fault_q;
    assign fault_pc = fault_pc_q;

    // FSM next state: a misaligned redirect halts the unit and latches the target.
    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        if (redir && misalign) begin
            state_d    = HALT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
        end
    end

    // Datapath next state: pointers, counters and PCs; a redirect flushes everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        live_d     = live_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (redir) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            live_d     = '0;
            // Everything still outstanding turns stale; a response arriving now is discarded.
            drop_d     = drop_q + live_q - CW'(rsp_drop || rsp_live);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
            if (push)     rsp_pc_d   = rsp_pc_q + STEP;
            live_d  = live_q + CW'(req_fire) - CW'(rsp_live);
            drop_d  = drop_q - CW'(rsp_drop);
            count_d = count_q + CW'(push) - CW'(pop);
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // State register for FSM, counters, pointers and fault capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_VEC;
            rsp_pc_q   <= RESET_VEC;
            count_q    <= '0;
            live_q     <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    // FIFO storage; cleared on reset so instr/instr_pc read 0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            pc_q   <= '0;
        end else if (push) begin
            data_q[wr_ptr_q] <= imem_rsp_data;
            pc_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with programmable latency,
// plus a narrow-address instance checking PC wrap-around.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fault;
    logic [31:0] fault_pc;

    // narrow instance: never gets responses, so it issues exactly DEPTH requests
    logic        r8_valid;
    logic [7:0]  r8_addr;
    logic        i8_valid;
    logic [31:0] i8_data;
    logic [7:0]  i8_pc;
    logic        f8;
    logic [7:0]  f8_pc;
    logic        zero1 = 1'b0;
    logic        one1  = 1'b1;
    logic [7:0]  zero8 = 8'h00;
    logic [31:0] zero32 = 32'h0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int nreq  = 0;
    int mem_lat = 1;
    logic [31:0] qa[$];
    int          qd[$];

    // values sampled mid-cycle by tick()
    logic        rv, iv, rv8;
    logic [31:0] ra, ipc, idat;
    logic [7:0]  ra8;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(32), .RESET_VEC(32'h0), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .fault(fault), .fault_pc(fault_pc)
    );

    fetch_unit #(.ADDR_W(8), .RESET_VEC(8'hF8), .DEPTH(4)) u8 (
        .clk(clk), .reset(reset),
        .redirect_valid(zero1), .redirect_pc(zero8),
        .imem_req_valid(r8_valid), .imem_req_ready(one1),
        .imem_req_addr(r8_addr),
        .imem_rsp_valid(zero1), .imem_rsp_data(zero32),
        .instr_valid(i8_valid), .instr_ready(one1),
        .instr(i8_data), .instr_pc(i8_pc),
        .fault(f8), .fault_pc(f8_pc)
    );

    function automatic logic [31:0] mk(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, want);
        end
    endtask

    // One clock cycle: present due response, sample outputs, model acceptance, advance.
    task automatic tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (qa.size() > 0 && qd[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mk(qa[0]);
        end
        #1;
        rv = imem_req_valid; ra = imem_req_addr;
        iv = instr_valid; ipc = instr_pc; idat = instr;
        rv8 = r8_valid; ra8 = r8_addr;
        if (imem_rsp_valid) begin
            void'(qa.pop_front());
            void'(qd.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            qa.push_back(imem_req_addr);
            qd.push_back(cyc + mem_lat);
            nreq++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        qa.delete();
        qd.delete();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        nreq = 0;
    endtask

    initial begin
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        hold_reset();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fault_pc", fault_pc, 0);
        release_reset();

        // 1: 1-cycle memory, decode always ready
        mem_lat = 1;
        tick(); chk("t1_c0_rv", rv, 1); chk("t1_c0_addr", ra, 32'h0);
        tick(); chk("t1_c1_addr", ra, 32'h4); chk("t1_c1_iv", iv, 0);
        tick(); chk("t1_c2_addr", ra, 32'h8); chk("t1_c2_iv", iv, 1);
                chk("t1_c2_pc", ipc, 32'h0); chk("t1_c2_data", idat, 32'hC0DE0000);
        tick(); chk("t1_c3_pc", ipc, 32'h4); chk("t1_c3_data", idat, 32'hC0DE0004);
        tick(); chk("t1_c4_pc", ipc, 32'h8); chk("t1_c4_iv", iv, 1);

        // 2: decode stalled, FIFO fills to DEPTH and requests stop
        hold_reset(); release_reset();
        instr_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("t2_nreq", nreq, 4);
        chk("t2_c6_rv", rv, 0);
        chk("t2_c6_head", ipc, 32'h0);
        instr_ready = 1'b1;
        tick(); chk("t2_c7_head", ipc, 32'h0); chk("t2_c7_rv", rv, 0);
        tick(); chk("t2_c8_head", ipc, 32'h4); chk("t2_c8_rv", rv, 1);
                chk("t2_c8_addr", ra, 32'h10);
        tick(); chk("t2_c9_head", ipc, 32'h8);
        tick(); chk("t2_c10_head", ipc, 32'hC);
        tick(); chk("t2_c11_head", ipc, 32'h10);

        // 3: 3-cycle memory, redirect with two responses outstanding
        hold_reset(); release_reset();
        mem_lat = 3;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick(); chk("t3_redir_rv", rv, 0);
        redirect_valid = 1'b0;
        tick(); chk("t3_c3_addr", ra, 32'h100); chk("t3_c3_iv", iv, 0);
        tick(); chk("t3_c4_iv", iv, 0);
        tick(); chk("t3_c5_iv", iv, 0);
        tick(); chk("t3_c6_iv", iv, 0);
        tick(); chk("t3_c7_iv", iv, 1); chk("t3_c7_pc", ipc, 32'h100);
                chk("t3_c7_data", idat, 32'hC0DE0100);
        tick(); chk("t3_c8_pc", ipc, 32'h104);

        // 4: redirect coinciding with a response and a pop
        hold_reset(); release_reset();
        mem_lat = 1;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick(); chk("t4_pop_iv", iv, 1); chk("t4_pop_pc", ipc, 32'h0);
                chk("t4_redir_rv", rv, 0);
        redirect_valid = 1'b0;
        tick(); chk("t4_c3_addr", ra, 32'h200); chk("t4_c3_iv", iv, 0);
        tick(); chk("t4_c4_iv", iv, 0);
        tick(); chk("t4_c5_iv", iv, 1); chk("t4_c5_pc", ipc, 32'h200);
                chk("t4_c5_data", idat, 32'hC0DE0200);

        // 5: misaligned redirect halts until reset
        hold_reset(); release_reset();
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        chk("t5_fault", fault, 1); chk("t5_fault_pc", fault_pc, 32'h102);
        nreq = 0;
        tick(); chk("t5_halt_rv", rv, 0); chk("t5_halt_iv", iv, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick(); chk("t5_halt_redir_rv", rv, 0);
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t5_halt_nreq", nreq, 0);
        chk("t5_fault_pc_kept", fault_pc, 32'h102);
        hold_reset();
        chk("t5_rst_fault", fault, 0); chk("t5_rst_fault_pc", fault_pc, 0);
        chk("t5_rst_rv", imem_req_valid, 0);
        chk("t5_rst_instr", instr, 0); chk("t5_rst_instr_pc", instr_pc, 0);
        release_reset();
        tick(); chk("t5_restart_rv", rv, 1); chk("t5_restart_addr", ra, 32'h0);

        // 6: 8-bit address wrap from 0xF8
        hold_reset(); release_reset();
        tick(); chk("t6_c0_addr", {24'h0, ra8}, 32'hF8); chk("t6_c0_rv", rv8, 1);
        tick(); chk("t6_c1_addr", {24'h0, ra8}, 32'hFC);
        tick(); chk("t6_c2_addr", {24'h0, ra8}, 32'h00);
        tick(); chk("t6_c3_addr", {24'h0, ra8}, 32'h04);
        tick(); chk("t6_c4_rv", rv8, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
